// File: rtl/fetch_sequencer_if.sv
// fetch_sequencer_if: instruction-memory and decode-side signals of the fetch stage.
interface fetch_sequencer_if;
    logic        stall;
    logic        PCSrc;
    logic [31:0] sl2;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] ins;
    logic [31:0] ins_pc;
    logic        ins_valid;
    logic        fetch_err;

    modport master (
        input  stall, PCSrc, sl2, imem_ack, imem_rdata,
        output imem_req, imem_addr, ins, ins_pc, ins_valid, fetch_err
    );

    modport slave (
        output stall, PCSrc, sl2, imem_ack, imem_rdata,
        input  imem_req, imem_addr, ins, ins_pc, ins_valid, fetch_err
    );
endinterface

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: owns the PC, fetches over req/ack, holds the word for decode, applies branches/stalls.
module fetch_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          MAX_WAIT = 15
) (
    input logic clk,
    input logic reset,
    fetch_sequencer_if.master bus
);
    typedef enum logic [2:0] {BOOT, REQ, WAIT, HOLD, ERR} state_t;
    localparam logic [7:0] MW = 8'(MAX_WAIT);
    state_t      state;
    logic [31:0] pc, ins, ins_pc, next_pc;
    logic [7:0]  wait_cnt;
    logic        req, valid, err;
    assign bus.imem_req  = req;
    assign bus.imem_addr = pc;
    assign bus.ins       = ins;
    assign bus.ins_pc    = ins_pc;
    assign bus.ins_valid = valid;
    assign bus.fetch_err = err;
    assign next_pc = ins_pc + 32'd4 + (bus.PCSrc ? bus.sl2 : 32'd0);
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= BOOT;
            pc       <= RESET_PC;
            req      <= 1'b0;
            ins      <= 32'd0;
            ins_pc   <= 32'd0;
            valid    <= 1'b0;
            err      <= 1'b0;
            wait_cnt <= 8'd0;
        end else begin
            case (state)
                BOOT: begin
                    state <= REQ;
                    req   <= 1'b1;
                end
                REQ, WAIT: begin
                    if (bus.imem_ack) begin
                        ins      <= bus.imem_rdata;
                        ins_pc   <= pc;
                        valid    <= 1'b1;
                        req      <= 1'b0;
                        wait_cnt <= 8'd0;
                        state    <= HOLD;
                    end else if (state == REQ) begin
                        wait_cnt <= 8'd1;
                        state    <= WAIT;
                    end else if (wait_cnt == MW) begin
                        req   <= 1'b0;
                        err   <= 1'b1;
                        state <= ERR;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                HOLD: begin
                    if (!bus.stall) begin
                        pc    <= next_pc;
                        valid <= 1'b0;
                        req   <= 1'b1;
                        state <= REQ;
                    end
                end
                default: begin
                    req   <= 1'b0;
                    valid <= 1'b0;
                    err   <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: directed checks of reset, fetch, wait, stall, branch, wrap, timeout and async reset.
module tb_fetch_sequencer;
    localparam logic [31:0] K = 32'hA5A5_0000;
    logic clk = 1'b0;
    logic reset;
    int   tests = 0;
    int   fails = 0;
    fetch_sequencer_if bus();
    fetch_sequencer #(.RESET_PC(32'h0), .MAX_WAIT(15)) dut (.clk(clk), .reset(reset), .bus(bus));
    always #5 clk = ~clk;
    // Memory returns a data word derived from the address so every capture is distinguishable.
    always_comb bus.imem_rdata = bus.imem_addr ^ K;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0;
        bus.imem_ack = 1'b1;
        bus.stall = 1'b0;
        bus.PCSrc = 1'b0;
        bus.sl2 = 32'd0;
        #2;
        chk("rst_req", {31'd0, bus.imem_req}, 32'd0);
        chk("rst_addr", bus.imem_addr, 32'd0);
        chk("rst_valid", {31'd0, bus.ins_valid}, 32'd0);
        chk("rst_ins", bus.ins, 32'd0);
        chk("rst_err", {31'd0, bus.fetch_err}, 32'd0);
        @(posedge clk);
        #1 reset = 1'b1;
        // Back-to-back fetch with immediate ack
        step(1);
        chk("t1_req0", {31'd0, bus.imem_req}, 32'd1);
        chk("t1_addr0", bus.imem_addr, 32'd0);
        step(1);
        chk("t1_valid0", {31'd0, bus.ins_valid}, 32'd1);
        chk("t1_ins0", bus.ins, K);
        chk("t1_inspc0", bus.ins_pc, 32'd0);
        chk("t1_reqlow", {31'd0, bus.imem_req}, 32'd0);
        // Delayed ack at PC 4: request held for four cycles
        bus.imem_ack = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step(1);
            chk("t2_req", {31'd0, bus.imem_req}, 32'd1);
            chk("t2_addr", bus.imem_addr, 32'd4);
            chk("t2_valid", {31'd0, bus.ins_valid}, 32'd0);
        end
        bus.imem_ack = 1'b1;
        step(1);
        chk("t2_valid", {31'd0, bus.ins_valid}, 32'd1);
        chk("t2_ins", bus.ins, 32'd4 ^ K);
        chk("t2_inspc", bus.ins_pc, 32'd4);
        chk("t2_err", {31'd0, bus.fetch_err}, 32'd0);
        step(1);
        chk("t1_addr8", bus.imem_addr, 32'd8);
        step(1);
        chk("t1_inspc8", bus.ins_pc, 32'd8);
        // Stall at ins_pc 8 with PCSrc/sl2 wiggling
        bus.stall = 1'b1;
        for (int i = 0; i < 5; i++) begin
            bus.PCSrc = i[0];
            bus.sl2 = 32'h100 * i;
            step(1);
            chk("t3_valid", {31'd0, bus.ins_valid}, 32'd1);
            chk("t3_ins", bus.ins, 32'd8 ^ K);
            chk("t3_inspc", bus.ins_pc, 32'd8);
            chk("t3_req", {31'd0, bus.imem_req}, 32'd0);
        end
        bus.stall = 1'b0;
        bus.PCSrc = 1'b1;
        bus.sl2 = 32'h10;
        step(1);
        chk("t3_br_addr", bus.imem_addr, 32'h1C);
        chk("t3_br_req", {31'd0, bus.imem_req}, 32'd1);
        chk("t3_br_valid", {31'd0, bus.ins_valid}, 32'd0);
        step(1);
        chk("t3_inspc1c", bus.ins_pc, 32'h1C);
        bus.PCSrc = 1'b0;
        step(1);
        chk("t4_addr20", bus.imem_addr, 32'h20);
        step(1);
        // Backward branch, then wrap past the top of the address space
        bus.PCSrc = 1'b1;
        bus.sl2 = 32'hFFFF_FFF0;
        step(1);
        chk("t4_back", bus.imem_addr, 32'h14);
        step(1);
        bus.sl2 = 32'hFFFF_FFE4;
        step(1);
        chk("t4_top", bus.imem_addr, 32'hFFFF_FFFC);
        step(1);
        chk("t4_top_inspc", bus.ins_pc, 32'hFFFF_FFFC);
        bus.PCSrc = 1'b0;
        step(1);
        chk("t4_wrap", bus.imem_addr, 32'd0);
        step(1);
        chk("t4_wrap_inspc", bus.ins_pc, 32'd0);
        // Timeout: 16 request cycles without ack, then sticky error
        bus.imem_ack = 1'b0;
        for (int i = 0; i < 16; i++) begin
            step(1);
            chk("t5_req", {31'd0, bus.imem_req}, 32'd1);
        end
        step(1);
        chk("t5_req_err", {31'd0, bus.imem_req}, 32'd0);
        chk("t5_err", {31'd0, bus.fetch_err}, 32'd1);
        chk("t5_valid", {31'd0, bus.ins_valid}, 32'd0);
        bus.imem_ack = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(1);
            chk("t5_late_err", {31'd0, bus.fetch_err}, 32'd1);
            chk("t5_late_req", {31'd0, bus.imem_req}, 32'd0);
            chk("t5_late_valid", {31'd0, bus.ins_valid}, 32'd0);
        end
        reset = 1'b0;
        #2;
        chk("t6_err_clr", {31'd0, bus.fetch_err}, 32'd0);
        @(posedge clk);
        #1 reset = 1'b1;
        // Async reset in the middle of a WAIT at PC 4
        step(2);
        chk("t6_inspc0", bus.ins_pc, 32'd0);
        bus.imem_ack = 1'b0;
        step(3);
        chk("t6_wait_req", {31'd0, bus.imem_req}, 32'd1);
        chk("t6_wait_addr", bus.imem_addr, 32'd4);
        #2 reset = 1'b0;
        #1;
        chk("t6_async_req", {31'd0, bus.imem_req}, 32'd0);
        chk("t6_async_addr", bus.imem_addr, 32'd0);
        chk("t6_async_valid", {31'd0, bus.ins_valid}, 32'd0);
        @(posedge clk);
        #1 reset = 1'b1;
        step(1);
        chk("t6_restart_req", {31'd0, bus.imem_req}, 32'd1);
        chk("t6_restart_addr", bus.imem_addr, 32'd0);
        // Ack on the timeout edge wins over the error
        step(15);
        chk("tb_last_req", {31'd0, bus.imem_req}, 32'd1);
        bus.imem_ack = 1'b1;
        step(1);
        chk("tb_ack_valid", {31'd0, bus.ins_valid}, 32'd1);
        chk("tb_ack_err", {31'd0, bus.fetch_err}, 32'd0);
        chk("tb_ack_ins", bus.ins, K);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
